fei4_frame_gen: RTL

- Emulated FE-I4 front-end data source that sits directly upstream of the 8b10b output serializer.
- Builds FE-I4 data frames in response to triggers and buffers them in an internal FIFO: Data Header, N hit data records, and optionally a Service Record.
- Its read port replaces the test-pattern data/empty pair: the serializer sees it as an ordinary FIFO.

---
 rtl/fei4_pkg.sv | 42 ++++
 rtl/fei4_frame_gen_if.sv | 18 +
 rtl/fei4_sync_fifo.sv | 57 +++++
 rtl/fei4_frame_gen.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fei4_pkg.sv
// Shared constants, record layouts and hit-pattern helpers for the emulated
// FE-I4 frame generator.
package fei4_pkg;

  localparam int WORD_W  = 24;
  localparam int BCID_W  = 10;
  localparam int LV1ID_W = 5;
  localparam int DROP_W  = 10;
  localparam int COL_W   = 7;
  localparam int ROW_W   = 9;
  localparam int TOT_W   = 4;
  localparam int LFSR_W  = 16;

  localparam logic [7:0] HDR_DH       = 8'hE9;
  localparam logic [7:0] HDR_AR       = 8'hEA;
  localparam logic [7:0] HDR_SR       = 8'hEF;
  localparam logic [5:0] SR_CODE_DROP = 6'd14;

  typedef enum logic [1:0] {IDLE, HEADER, HITS, SR} state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TOT_W-1:0] tot1;
    logic [TOT_W-1:0] tot2;
  } hit_rec_t;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[LFSR_W-1:1]};
  endfunction

  function automatic hit_rec_t hit_from_lfsr(input logic [LFSR_W-1:0] s);
    hit_rec_t r;
    r.col  = {1'b0, s[5:0]} + 7'd1;
    r.row  = {1'b0, s[15:8]} + 9'd1;
    r.tot1 = (s[3:0] == 4'hF) ? 4'hE : s[3:0];
    r.tot2 = 4'hF;
    return r;
  endfunction

endpackage

// File: rtl/fei4_frame_gen_if.sv
// Trigger input and FIFO-style read port of the FE-I4 frame generator.
interface fei4_frame_gen_if;
  import fei4_pkg::*;

  logic                 trigger;
  logic [3:0]           hits;
  logic                 read;
  logic                 empty;
  logic [WORD_W-1:0]    data;
  logic                 busy;
  logic [LV1ID_W-1:0]   lv1id;
  logic [DROP_W-1:0]    drop_cnt;

  modport master (output trigger, hits, read,
                  input  empty, data, busy, lv1id, drop_cnt);
  modport slave  (input  trigger, hits, read,
                  output empty, data, busy, lv1id, drop_cnt);
endinterface

// File: rtl/fei4_sync_fifo.sv
// Single-clock FIFO with registered read data and registered empty flag.
module fei4_sync_fifo #(
  parameter int AW = 5,
  parameter int DW = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write,
  input  logic [DW-1:0] wdata,
  input  logic          read,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_next;
  logic          do_read;

  assign do_read = read && !empty;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (write && !do_read)      count_next = count + CNT_ONE;
    else if (do_read && !write) count_next = count - CNT_ONE;
  end

  // NOTE: storage array has no reset; only pointers and flags define validity.
  always_ff @(posedge clock) begin
    if (write) mem[wptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      rdata <= '0;
    end else begin
      count <= count_next;
      empty <= (count_next == '0);
      if (write) wptr <= wptr + PTR_ONE;
      if (do_read) begin
        rdata <= mem[rptr];
        rptr  <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fei4_frame_gen.sv
// Emulated FE-I4 data source: trigger-driven frame builder feeding a FIFO.
// Define FEI4_DROP_SR_EN to append a drop-count Service Record to frames.
module fei4_frame_gen
  import fei4_pkg::*;
#(
  parameter int              FIFO_AW   = 5,
  parameter int              MAX_HITS  = 15,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  fei4_frame_gen_if.slave  bus
);

  localparam logic [3:0] MAX_NH = (MAX_HITS > 15) ? 4'd15 : 4'(MAX_HITS);

  state_t              state, state_next, after_data;
  logic [BCID_W-1:0]   bcid, bcid_lat;
  logic [LV1ID_W-1:0]  lv1id;
  logic [DROP_W-1:0]   drop_cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic [3:0]          nh_req, nh_left;
  logic [31:0]         frame_len, free_words;
  logic                sr_pend, accept;
  logic                fifo_write;
  logic [WORD_W-1:0]   fifo_wdata;
  logic [FIFO_AW:0]    fifo_count;

  assign nh_req     = (bus.hits > MAX_NH) ? MAX_NH : bus.hits;
  assign frame_len  = 32'(nh_req) + 32'd1 + 32'(sr_pend);
  assign free_words = 32'(2**FIFO_AW) - 32'(fifo_count);
  assign accept     = bus.trigger && (state == IDLE) && (free_words >= frame_len);

`ifdef FEI4_DROP_SR_EN
  logic              sr_flag;
  logic [DROP_W-1:0] drop_reported;

  assign sr_pend    = (drop_cnt != drop_reported);
  assign after_data = sr_flag ? SR : IDLE;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sr_flag       <= 1'b0;
      drop_reported <= '0;
    end else begin
      if (accept)       sr_flag       <= sr_pend;
      if (state == SR)  drop_reported <= drop_cnt;
    end
  end
`else
  assign sr_pend    = 1'b0;
  assign after_data = IDLE;
`endif

  always_comb begin
    state_next = state;
    fifo_write = 1'b0;
    fifo_wdata = '0;
    case (state)
      IDLE: if (accept) state_next = HEADER;
      HEADER: begin
        fifo_write = 1'b1;
        fifo_wdata = {HDR_DH, 1'b0, lv1id, bcid_lat};
        state_next = (nh_left != 4'd0) ? HITS : after_data;
      end
      HITS: begin
        fifo_write = 1'b1;
        fifo_wdata = hit_from_lfsr(lfsr);
        if (nh_left == 4'd1) state_next = after_data;
      end
`ifdef FEI4_DROP_SR_EN
      SR: begin
        fifo_write = 1'b1;
        fifo_wdata = {HDR_SR, SR_CODE_DROP, drop_cnt};
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      bcid     <= '0;
      bcid_lat <= '0;
      lv1id    <= '0;
      drop_cnt <= '0;
      lfsr     <= LFSR_SEED;
      nh_left  <= '0;
    end else begin
      state <= state_next;
      bcid  <= bcid + 10'd1;
      if (accept) begin
        nh_left  <= nh_req;
        bcid_lat <= bcid;
      end
      if (bus.trigger && !accept && (drop_cnt != '1)) drop_cnt <= drop_cnt + 10'd1;
      if (state == HEADER) lv1id <= lv1id + 5'd1;
      if (state == HITS) begin
        lfsr    <= lfsr_step(lfsr);
        nh_left <= nh_left - 4'd1;
      end
    end
  end

  fei4_sync_fifo #(.AW(FIFO_AW), .DW(WORD_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .write (fifo_write),
    .wdata (fifo_wdata),
    .read  (bus.read),
    .rdata (bus.data),
    .empty (bus.empty),
    .count (fifo_count)
  );

  assign bus.busy     = (state != IDLE);
  assign bus.lv1id    = lv1id;
  assign bus.drop_cnt = drop_cnt;

endmodule
